// File: rtl/regsfile_pkg.sv
// Shared constants and types for the integer register file
// and its busy-bit scoreboard.
package regsfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regsfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations and flags
// writebacks to registers that had no pending producer.
module regsfile_scoreboard
  import regsfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic          wb_unexp
);

  logic wr_nz;
  logic iss_hit_wr;

  assign wr_nz      = wr_en && (wr_addr != AW'(REG_ZERO));
  assign iss_hit_wr = iss_en && (iss_addr == wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      wb_unexp <= 1'b0;
    end else begin
      busy_vec[0] <= 1'b0;
      // Set beats clear: a new producer issuing as the old one retires.
      for (int r = 1; r < NREGS; r++) begin
        if (iss_en && iss_addr == AW'(r))
          busy_vec[r] <= 1'b1;
        else if (wr_en && wr_addr == AW'(r))
          busy_vec[r] <= 1'b0;
      end
      if (wr_nz && !busy_vec[wr_addr] && !iss_hit_wr)
        wb_unexp <= 1'b1;
    end
  end

endmodule

// File: rtl/regsfile_sb.sv
// Integer register file with NRD combinational read ports,
// one write port, write-to-read bypass and busy scoreboard.
module regsfile_sb
  import regsfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic              wb_unexp
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr_en && wr_addr != AW'(REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Gated by rst_n so the bypass path cannot leak data in reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rst_n && rd_addr[i*AW +: AW] != AW'(REG_ZERO)) begin
        if (wr_en && wr_addr == rd_addr[i*AW +: AW]) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
          rd_busy[i] = busy_vec[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  regsfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .busy_vec(busy_vec),
    .wb_unexp(wb_unexp)
  );

endmodule

// File: tb/tb_regsfile_sb.sv
// Scoreboard bench for regsfile_sb: directed scenarios then
// random traffic against an array-based reference model.
module tb_regsfile_sb;
  import regsfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  logic [NREGS-1:0] busy_vec;
  logic wb_unexp;

  regsfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec), .wb_unexp(wb_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0] busy;
    logic [NREGS-1:0] bv;
    logic unexp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [NREGS];
  bit m_busy [NREGS];
  bit m_unexp;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 0;
    end
    m_unexp = 0;
  endtask

  // Call at posedge+1: drive inputs, queue expected view, advance model.
  task automatic drive(bit we, int wa, logic [XLEN-1:0] wd,
                       bit ie, int ia, int a0, int a1);
    exp_t e;
    int a[NRD];
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia);
    rd_addr = {AW'(a1), AW'(a0)};
    a[0] = a0; a[1] = a1;
    e.data = '0; e.busy = '0; e.bv = '0;
    for (int i = 0; i < NRD; i++) begin
      if (a[i] == 0) begin
      end else if (we && wa == a[i]) begin
        e.data[i*XLEN +: XLEN] = wd;
      end else begin
        e.data[i*XLEN +: XLEN] = m_regs[a[i]];
        e.busy[i] = m_busy[a[i]];
      end
    end
    for (int r = 1; r < NREGS; r++) e.bv[r] = m_busy[r];
    e.unexp = m_unexp;
    q.push_back(e);
    if (we && wa != 0) begin
      if (!m_busy[wa] && !(ie && ia == wa)) m_unexp = 1;
      m_regs[wa] = wd;
      m_busy[wa] = 0;
    end
    if (ie && ia != 0) m_busy[ia] = 1;
  endtask

  task automatic cyc(bit we, int wa, logic [XLEN-1:0] wd,
                     bit ie, int ia, int a0, int a1);
    @(posedge clk); #1;
    drive(we, wa, wd, ie, ia, a0, a1);
  endtask

  // Monitor: compare the DUT's view at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e.data));
        chk("rd_busy", 64'(rd_busy), 64'(e.busy));
        chk("busy_vec", 64'(busy_vec), 64'(e.bv));
        chk("wb_unexp", 64'(wb_unexp), 64'(e.unexp));
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b0; iss_addr = '0;
    rd_addr = {AW'(5), AW'(0)};
    #1;
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_wb_unexp", 64'(wb_unexp), 64'd0);
    repeat (2) @(posedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd_data", 64'(rd_data), 64'd0);

    // x0 immunity
    cyc(1, 0, 32'h1234, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Scoreboard lifecycle on 7
    cyc(0, 0, 0, 1, 7, 7, 0);
    cyc(0, 0, 0, 0, 0, 7, 7);
    cyc(1, 7, 32'h77, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 7, 0);
    // Simultaneous set/clear on 9
    cyc(0, 0, 0, 1, 9, 0, 0);
    cyc(1, 9, 32'hA5, 1, 9, 9, 0);
    cyc(0, 0, 0, 0, 0, 9, 9);
    // Unexpected writebacks: bypass then stored value
    cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 5);
    cyc(1, 3, 32'h0333, 0, 0, 3, 5);
    cyc(0, 0, 0, 0, 0, 3, 5);
    cyc(0, 0, 0, 0, 0, 3, 0);

    // Mid-cycle asynchronous reset
    @(negedge clk); #1;
    chk("pre_rst_unexp", 64'(wb_unexp), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_unexp", 64'(wb_unexp), 64'd0);
    chk("mid_rst_busy_vec", 64'(busy_vec), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_reg3", 64'(rd_data[XLEN-1:0]), 64'd0);

    // Random traffic, small index range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      int wa, ia;
      wa = $urandom_range(0, 7);
      ia = $urandom_range(0, 7);
      cyc($urandom_range(0, 2) == 0, wa, $urandom,
          $urandom_range(0, 2) == 0, ia,
          $urandom_range(0, 3) == 0 ? $urandom_range(0, 31)
                                    : $urandom_range(0, 7),
          $urandom_range(0, 7));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
